// File: rtl/tc_rst_pkg.sv
// Shared definitions for the PL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tc_rst_pkg;

    // FSM encoding, also exported on state_o for the PS register map.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Lock-loss event counter width and its saturation value.
    localparam int                LOST_W   = 8;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

endpackage

// File: rtl/tc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Latency: SYNC_STAGES clk edges from d_i to q_o.
// Backpressure: none, free-running sampler.
// Ports: clk, rst (async active-low, clears chain to 0), d_i (async), q_o (synchronised).
module tc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tc_rst_seq.sv
// Reset sequencer: holds NDOM reset domains until lock is stable, releases them in order.
// Latency: all outputs registered; lock loss reaches rst_o in SYNC_STAGES+1 edges, sw_rst_i in 1.
// Backpressure: none; sw_rst_i is a single-cycle pulse, dly_i is sampled once on release start.
// Ports: clk, rst (async active-low), lock_i (async), sw_rst_i, dly_i (gap per domain),
//        rst_o (active-high domain resets), done_o, state_o, lock_lost_cnt_o.
module tc_rst_seq
    import tc_rst_pkg::*;
#(
    parameter int NDOM        = 4,
    parameter int CNTW        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HOLD    = 64,
    parameter int LOCK_FILT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock_i,
    input  logic                   sw_rst_i,
    input  logic [NDOM*CNTW-1:0]   dly_i,
    output logic [NDOM-1:0]        rst_o,
    output logic                   done_o,
    output logic [1:0]             state_o,
    output logic [LOST_W-1:0]      lock_lost_cnt_o
);

    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int IDX_W  = (NDOM > 1) ? $clog2(NDOM) : 1;

    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NDOM - 1);

    state_t                        state_q, state_d;
    logic                          lock_s;
    logic [FILT_W-1:0]             filt_q, filt_d;
    logic [HOLD_W-1:0]             hold_q, hold_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NDOM-1:0][CNTW-1:0]     dly_q, dly_d;
    logic [NDOM-1:0]               rst_q, rst_d;
    logic                          done_q, done_d;
    logic [LOST_W-1:0]             lost_q, lost_d;

    logic                          lock_ok;
    logic                          hold_ok;
    logic                          abort;
    logic                          rel_hit;
    logic                          rel_last;
    logic [CNTW-1:0]               dly_sel;
    logic [NDOM-1:0]               dom_mask;

    // Only lock_i crosses in; every other input is already in the clk domain.
    tc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (lock_i),
        .q_o (lock_s)
    );

    assign lock_ok  = (filt_q == FILT_MAX);
    assign hold_ok  = (hold_q == HOLD_MAX);
    assign abort    = (state_q != ST_HOLD) && (!lock_s || sw_rst_i);
    assign rel_hit  = (cnt_q == dly_sel);
    assign rel_last = (idx_q == IDX_LAST);

    // Gap and one-hot release mask for the domain currently being counted.
    always_comb begin
        dly_sel  = '0;
        dom_mask = '0;
        for (int i = 0; i < NDOM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dly_sel     = dly_q[i];
                dom_mask[i] = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A software request in HOLD restarts the hold time, so it also blocks the exit.
            ST_HOLD:    if (!sw_rst_i && hold_ok && lock_ok) state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (abort)                    state_d = ST_HOLD;
                else if (rel_hit && rel_last) state_d = ST_RUN;
            end
            ST_RUN:     if (abort) state_d = ST_HOLD;
            default:    state_d = ST_HOLD;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        filt_d = filt_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        dly_d  = dly_q;
        rst_d  = rst_q;
        done_d = done_q;
        lost_d = lost_q;

        // Lock filter runs in every state; abort restarts it even if lock stays high.
        if (!lock_s || abort) begin
            filt_d = '0;
        end else if (!lock_ok) begin
            filt_d = filt_q + FILT_W'(1);
        end

        case (state_q)
            ST_HOLD: begin
                rst_d  = '1;
                done_d = 1'b0;
                if (sw_rst_i) begin
                    hold_d = '0;
                end else if (!hold_ok) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (state_d == ST_RELEASE) begin
                    dly_d = dly_i;
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            ST_RELEASE: begin
                // Compare-equal means a gap of N costs N+1 cycles and cnt never wraps.
                if (!abort) begin
                    if (rel_hit) begin
                        rst_d = rst_q & ~dom_mask;
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (rel_last) done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: ;
        endcase

        if (abort) begin
            rst_d  = '1;
            done_d = 1'b0;
            hold_d = '0;
            // Count only lock-driven aborts; a coincident sw request is one event.
            if (!lock_s && (lost_q != LOST_MAX)) begin
                lost_d = lost_q + LOST_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            dly_q  <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
            lost_q <= '0;
        end else begin
            filt_q <= filt_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dly_q  <= dly_d;
            rst_q  <= rst_d;
            done_q <= done_d;
            lost_q <= lost_d;
        end
    end

    assign rst_o           = rst_q;
    assign done_o          = done_q;
    assign state_o         = state_q;
    assign lock_lost_cnt_o = lost_q;

endmodule

// File: tb/tb_tc_rst_seq.sv
// Directed bench for tc_rst_seq with NDOM=4, MIN_HOLD=8, LOCK_FILT=4, dly={0,3,10,1}.
// Latency: n/a.
// Backpressure: n/a.
module tb_tc_rst_seq;

    logic        clk;
    logic        rst;
    logic        lock_i;
    logic        sw_rst_i;
    logic [63:0] dly_i;
    logic [3:0]  rst_o;
    logic        done_o;
    logic [1:0]  state_o;
    logic [7:0]  lock_lost_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       lock;
        logic       sw;
        int         adv;
        logic [3:0] rst;
        logic       done;
        logic [1:0] st;
        logic [7:0] lost;
    } vec_t;

    vec_t vq[$];

    tc_rst_seq #(
        .NDOM        (4),
        .CNTW        (16),
        .SYNC_STAGES (2),
        .MIN_HOLD    (8),
        .LOCK_FILT   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lock_i          (lock_i),
        .sw_rst_i        (sw_rst_i),
        .dly_i           (dly_i),
        .rst_o           (rst_o),
        .done_o          (done_o),
        .state_o         (state_o),
        .lock_lost_cnt_o (lock_lost_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        lock_i   = 1'b1;
        sw_rst_i = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (int'(state_o) != target && n < budget) begin
            step(1);
            n++;
        end
        chk($sformatf("wait_state_%0d", target), int'(state_o), target);
    endtask

    function automatic void add(input logic lk, input logic sw, input int adv,
                                input logic [3:0] r, input logic d,
                                input logic [1:0] s, input logic [7:0] l);
        vec_t v;
        v.lock = lk; v.sw = sw; v.adv = adv;
        v.rst = r; v.done = d; v.st = s; v.lost = l;
        vq.push_back(v);
    endfunction

    // Nominal release timeline relative to the point where HOLD starts fresh.
    function automatic void add_nominal(input logic [7:0] l);
        add(1, 0, 8,  4'hF, 0, 0, l);
        add(1, 0, 1,  4'hF, 0, 1, l);
        add(1, 0, 1,  4'hE, 0, 1, l);
        add(1, 0, 3,  4'hE, 0, 1, l);
        add(1, 0, 1,  4'hC, 0, 1, l);
        add(1, 0, 10, 4'hC, 0, 1, l);
        add(1, 0, 1,  4'h8, 0, 1, l);
        add(1, 0, 1,  4'h8, 0, 1, l);
        add(1, 0, 1,  4'h0, 1, 2, l);
        add(1, 0, 5,  4'h0, 1, 2, l);
    endfunction

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            lock_i   = vq[i].lock;
            sw_rst_i = vq[i].sw;
            step(vq[i].adv);
            chk($sformatf("%s[%0d].rst_o", tag, i),   int'(rst_o),           int'(vq[i].rst));
            chk($sformatf("%s[%0d].done_o", tag, i),  int'(done_o),          int'(vq[i].done));
            chk($sformatf("%s[%0d].state_o", tag, i), int'(state_o),         int'(vq[i].st));
            chk($sformatf("%s[%0d].lost", tag, i),    int'(lock_lost_cnt_o), int'(vq[i].lost));
        end
        vq.delete();
    endtask

    initial begin
        dly_i    = {16'd1, 16'd10, 16'd3, 16'd0};
        rst      = 1'b0;
        lock_i   = 1'b1;
        sw_rst_i = 1'b0;
        step(2);
        chk("reset.rst_o",   int'(rst_o),           15);
        chk("reset.done_o",  int'(done_o),          0);
        chk("reset.state_o", int'(state_o),         0);
        chk("reset.lost",    int'(lock_lost_cnt_o), 0);
        rst = 1'b1;

        // Nominal release, one-cycle lock drop in RUN, then identical re-sequence.
        add_nominal(8'd0);
        add(0, 0, 1, 4'h0, 1, 2, 8'd0);
        add(1, 0, 1, 4'h0, 1, 2, 8'd0);
        add(1, 0, 1, 4'hF, 0, 0, 8'd1);
        add_nominal(8'd1);
        run_vecs("nom");

        // Lock glitch in HOLD while the filter is at 3: release start moves from edge 9 to 11.
        do_reset();
        step(3);
        lock_i = 1'b0;
        step(1);
        lock_i = 1'b1;
        step(6);
        chk("glitch.e10.state", int'(state_o), 0);
        step(1);
        chk("glitch.e11.state", int'(state_o), 1);
        chk("glitch.e11.rst",   int'(rst_o),   15);
        step(1);
        chk("glitch.e12.rst",   int'(rst_o),   14);
        chk("glitch.lost",      int'(lock_lost_cnt_o), 0);

        // Software reset while domain 2 is counting its gap.
        do_reset();
        step(18);
        chk("sw.e18.rst", int'(rst_o), 12);
        sw_rst_i = 1'b1;
        step(1);
        sw_rst_i = 1'b0;
        chk("sw.e19.rst",   int'(rst_o),           15);
        chk("sw.e19.done",  int'(done_o),          0);
        chk("sw.e19.state", int'(state_o),         0);
        chk("sw.e19.lost",  int'(lock_lost_cnt_o), 0);
        step(8);
        chk("sw.e27.state", int'(state_o), 0);
        step(1);
        chk("sw.e28.state", int'(state_o), 1);
        step(1);
        chk("sw.e29.rst",   int'(rst_o),   14);

        // Lock loss coinciding with sw_rst_i in RUN counts once.
        step(17);
        chk("both.e46.state", int'(state_o), 2);
        chk("both.e46.done",  int'(done_o),  1);
        lock_i = 1'b0;
        step(1);
        lock_i = 1'b1;
        step(1);
        sw_rst_i = 1'b1;
        step(1);
        sw_rst_i = 1'b0;
        chk("both.lost",  int'(lock_lost_cnt_o), 1);
        chk("both.rst",   int'(rst_o),           15);
        chk("both.state", int'(state_o),         0);

        // Saturation: abort from RELEASE repeatedly via one-cycle lock drops.
        for (int k = 1; k <= 300; k++) begin
            wait_state(1, 50);
            lock_i = 1'b0;
            step(1);
            lock_i = 1'b1;
            step(2);
            if (k == 253) chk("sat.k253", int'(lock_lost_cnt_o), 254);
            if (k == 254) chk("sat.k254", int'(lock_lost_cnt_o), 255);
        end
        chk("sat.final", int'(lock_lost_cnt_o), 255);

        // Asynchronous reset pulse in RUN acts without a clock edge.
        wait_state(2, 60);
        chk("arst.pre.lost", int'(lock_lost_cnt_o), 255);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.rst",   int'(rst_o),           15);
        chk("arst.done",  int'(done_o),          0);
        chk("arst.state", int'(state_o),         0);
        chk("arst.lost",  int'(lock_lost_cnt_o), 0);
        #1;
        rst = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
